// File: rtl/t05_pack_pkg.sv
// rtl/t05_pack_pkg.sv - shared types, constants and CRC helper for the bit packer
package t05_pack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PACK,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } pack_state_e;

  localparam logic [7:0] CRC8_POLY         = 8'h07;
  localparam logic [3:0] PACK_ACTIVE_STATE = 4'd5;

  // One byte of CRC-8, MSB-first, no reflection, no final xor
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/t05_byte_fifo.sv
// rtl/t05_byte_fifo.sv - 8-bit first-word fall-through byte FIFO
module t05_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  // A push while full is only honoured when the head leaves in the same cycle
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Storage array needs no reset: contents are only visible when count is nonzero
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/t05_bit_packer.sv
// rtl/t05_bit_packer.sv - MSB-first serial-to-byte packer with FIFO; optional CRC byte via T05_BIT_PACKER_CRC_EN
module t05_bit_packer
  import t05_pack_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [3:0] ACTIVE_STATE = PACK_ACTIVE_STATE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  en_state,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        flush,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        stall,
  output logic [31:0] byte_count,
  output logic        done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  pack_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] byte_count_q;

  logic        active, accept, push, pop;
  logic [7:0]  push_data, byte_full, pad_byte;
  logic        fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

`ifdef T05_BIT_PACKER_CRC_EN
  logic [7:0]  crc_q, crc_d;
  logic        crc_push;
`endif

  assign active    = (en_state == ACTIVE_STATE);
  assign accept    = active && bit_valid && !stall;
  assign byte_full = {shift_q[6:0], bit_in};
  // Remaining bits moved to the top, zeros fill the LSB side
  assign pad_byte  = shift_q << (4'd8 - {1'b0, cnt_q});
  assign pop       = byte_valid && byte_ready;

  assign byte_valid = !fifo_empty;
  assign stall      = fifo_full;
  assign byte_count = byte_count_q;
  assign done       = (state_q == ST_DONE);

  // Next-state and FIFO push decode; a bit in the flush cycle is packed before FLUSH looks at the count
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_data = byte_full;
`ifdef T05_BIT_PACKER_CRC_EN
    crc_push  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (active) state_d = ST_PACK;
      end
      ST_PACK: begin
        if (accept) begin
          shift_d = byte_full;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) push = 1'b1;
        end
        if (active && flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (cnt_q != 3'd0) begin
          if (!stall) begin
            push      = 1'b1;
            push_data = pad_byte;
            cnt_d     = 3'd0;
          end
        end else begin
`ifdef T05_BIT_PACKER_CRC_EN
          if (!stall) begin
            push      = 1'b1;
            push_data = crc_q;
            crc_push  = 1'b1;
            state_d   = ST_DRAIN;
          end
`else
          state_d = ST_DRAIN;
`endif
        end
      end
      ST_DRAIN: begin
        if (fifo_count == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef T05_BIT_PACKER_CRC_EN
  // CRC covers every data and pad byte, never the CRC byte itself
  always_comb begin
    crc_d = crc_q;
    if (push && !crc_push) crc_d = crc8_update(crc_q, push_data);
  end

  // CRC accumulator register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) crc_q <= 8'h00;
    else      crc_q <= crc_d;
  end
`endif

  // State, shift register, bit counter and handoff counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= 8'h00;
      cnt_q        <= 3'd0;
      byte_count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      if (pop) byte_count_q <= byte_count_q + 32'd1;
    end
  end

  t05_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (byte_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_t05_bit_packer.sv
// tb/tb_t05_bit_packer.sv - scoreboard bench for t05_bit_packer
module tb_t05_bit_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en_state;
  logic        bit_in, bit_valid, flush;
  logic [7:0]  byte_out;
  logic        byte_valid, byte_ready, stall, done;
  logic [31:0] byte_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  held;
  logic        held_v = 1'b0;

  always #5 clk = ~clk;

  t05_bit_packer #(.FIFO_DEPTH(4), .ACTIVE_STATE(4'd5)) dut (
    .clk(clk), .rst(rst), .en_state(en_state), .bit_in(bit_in),
    .bit_valid(bit_valid), .flush(flush), .byte_out(byte_out),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .stall(stall),
    .byte_count(byte_count), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_crc(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  // Monitor: compare each handshake against the scoreboard, and check hold stability
  always @(negedge clk) begin
    if (held_v && byte_valid) check("hold_stable", {24'd0, byte_out}, {24'd0, held});
    if (byte_valid && byte_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_byte: got 0x%0h, none expected", byte_out);
      end else begin
        check("byte_out", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
      end
      held_v = 1'b0;
    end else if (byte_valid) begin
      held   = byte_out;
      held_v = 1'b1;
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fl = 1'b0);
    bit_in    = b;
    bit_valid = 1'b1;
    flush     = fl;
    tick();
    bit_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic expect_out);
    if (expect_out) exp_q.push_back(v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; en_state = 4'd0; bit_valid = 1'b0; flush = 1'b0; bit_in = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic start();
    en_state = 4'd5;
    tick();
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; en_state = 4'd0; bit_in = 1'b0; bit_valid = 1'b0;
    flush = 1'b0; byte_ready = 1'b1;
    #2 rst = 1'b0;
    tick();
    check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_byte_count", byte_count, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    tick();

    // 16 bits -> 0xAC, 0x0F
    start();
    send_byte(8'hAC, 1'b1);
    send_byte(8'h0F, 1'b1);
    wait_cycles(4);
    check("t1_byte_count", byte_count, 32'd2);
    check("t1_sb_empty", exp_q.size(), 32'd0);
    check("t1_not_done", {31'd0, done}, 32'd0);

    // 11 bits + flush -> 0xFF, 0xA0 (then CRC if enabled)
    do_reset();
    start();
    send_byte(8'hFF, 1'b1);
    exp_q.push_back(8'hA0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
`ifdef T05_BIT_PACKER_CRC_EN
    exp_q.push_back(ref_crc(ref_crc(8'h00, 8'hFF), 8'hA0));
`endif
    pulse_flush();
    wait_done(50);
`ifdef T05_BIT_PACKER_CRC_EN
    check("t2_byte_count", byte_count, 32'd3);
`else
    check("t2_byte_count", byte_count, 32'd2);
`endif
    check("t2_sb_empty", exp_q.size(), 32'd0);

    // Backpressure: fill FIFO, stall, dropped bit, ordered release
    do_reset();
    byte_ready = 1'b0;
    start();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    check("t3_not_stall_before_4th", {31'd0, stall}, 32'd0);
    send_byte(8'h44, 1'b1);
    check("t3_stall_full", {31'd0, stall}, 32'd1);
    send_bit(1'b1);
    check("t3_stall_held", {31'd0, stall}, 32'd1);
    check("t3_no_handoff", byte_count, 32'd0);
    byte_ready = 1'b1;
    wait_cycles(6);
    check("t3_stall_clear", {31'd0, stall}, 32'd0);
    send_byte(8'h55, 1'b1);
    wait_cycles(3);
    check("t3_byte_count", byte_count, 32'd5);
    check("t3_sb_empty", exp_q.size(), 32'd0);

    // Reset mid-byte with two bytes queued
    byte_ready = 1'b0;
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    check("t5_queued_valid", {31'd0, byte_valid}, 32'd1);
    rst = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, byte_valid}, 32'd0);
    check("t5_rst_count", byte_count, 32'd0);
    tick();
    rst = 1'b1;
    byte_ready = 1'b1;
    start();
    send_byte(8'h96, 1'b1);
    wait_cycles(4);
    check("t5_byte_count", byte_count, 32'd1);
    check("t5_sb_empty", exp_q.size(), 32'd0);

    // 8th bit and flush in the same cycle -> one byte, no pad
    do_reset();
    start();
    exp_q.push_back(8'h3C);
`ifdef T05_BIT_PACKER_CRC_EN
    exp_q.push_back(ref_crc(8'h00, 8'h3C));
`endif
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b0, 1'b1);
    wait_done(50);
`ifdef T05_BIT_PACKER_CRC_EN
    check("t4_byte_count", byte_count, 32'd2);
`else
    check("t4_byte_count", byte_count, 32'd1);
`endif
    check("t4_sb_empty", exp_q.size(), 32'd0);

`ifdef T05_BIT_PACKER_CRC_EN
    // CRC trailer: 0x01, 0x02 -> 0x1B
    do_reset();
    start();
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    exp_q.push_back(8'h1B);
    pulse_flush();
    wait_done(50);
    check("t6_byte_count", byte_count, 32'd3);
    check("t6_sb_empty", exp_q.size(), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/t05_bit_packer.md
Name: t05_bit_packer

Overview:
- Serial-to-byte stage directly downstream of the Huffman translation stage (enable state 5).
- Collects the `writeBin` bits qualified by `writeEn` (32-bit character-count header followed by code paths), packs them MSB-first into bytes, and buffers them in a small FIFO.
- Hands bytes to the SPI/SD writer with a valid/ready handshake.
- On the translation stage's finish pulse, pads the last partial byte with zeros, drains, and raises `done`.

Parameters:
- FIFO_DEPTH, 4: byte FIFO entries; power of 2, 2..16.
- ACTIVE_STATE, 5: `en_state` value in which bits are accepted.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- en_state  in  4  global FSM state
- bit_in  in  1  serial data bit (translation `writeBin`)
- bit_valid  in  1  `bit_in` valid this cycle (translation `writeEn`)
- flush  in  1  end-of-stream pulse (translation `fin_state`)
- byte_out  out  8  packed byte, FIFO head
- byte_valid  out  1  `byte_out` valid
- byte_ready  in  1  downstream accepts `byte_out`
- stall  out  1  FIFO full; upstream must hold
- byte_count  out  32  bytes handed off since reset
- done  out  1  stream complete; held high until reset

Behaviour:
- Reset (rst=0, async) values:
  - shift register 0, bit counter 0, FIFO empty.
  - `byte_valid`=0, `stall`=0, `byte_count`=0, `done`=0, state IDLE.
- States and transitions:
  - IDLE: go to PACK when `en_state`==ACTIVE_STATE.
  - PACK: each cycle with `en_state`==ACTIVE_STATE, `bit_valid`=1 and `stall`=0:
    - shift = {shift[6:0], bit_in}; bit counter increments.
    - On the 8th bit, the completed byte is written to the FIFO in the same edge and the counter wraps to 0.
  - FLUSH (entered from PACK on `flush`=1 in ACTIVE_STATE):
    - If bit counter ≠ 0, write shift << (8 − count), i.e. zero-padded on the LSB side, as one byte once the FIFO has space.
    - If bit counter = 0, write nothing. Then go to DRAIN.
  - DRAIN: wait for the FIFO to empty, then go to DONE.
  - DONE: `done`=1; all inputs ignored until reset.
- Simultaneous `bit_valid` and `flush` in the same cycle: the bit is packed first, then the flush evaluates the updated count. A bit completing a byte plus flush yields exactly one byte and no pad byte.
- Bits arriving while `en_state` ≠ ACTIVE_STATE, or while `stall`=1, are dropped. Upstream honours `stall`.
- `stall` = FIFO full, combinational from the registered FIFO count.
- FIFO output handshake:
  - `byte_out`/`byte_valid` are driven from the FIFO head; `byte_valid` = !empty.
  - Transfer occurs when `byte_valid` & `byte_ready`.
  - `byte_out` is stable while valid and not ready.
- FIFO concurrency: simultaneous push and pop when full is allowed (count unchanged). Push when full never happens because input is gated by `stall`.
- Latency: 8th bit at edge N → `byte_valid` high after edge N (first-word fall-through, one cycle).
- `byte_count` increments on each handshake and wraps modulo 2^32.
- Reset mid-stream discards all buffered bits and bytes.

Optional Feature:
- Macro: T05_BIT_PACKER_CRC_EN.
- When defined:
  - CRC-8 (poly 0x07, init 0x00, MSB-first) runs over every byte pushed into the FIFO, including the pad byte.
  - After FLUSH, one extra byte holding the final CRC is pushed before DRAIN; it is not itself included in the CRC.
  - `byte_count` includes the CRC byte.
- When undefined: no CRC logic and no extra byte.

Decomposition:
- Package t05_pack_pkg holds:
  - state enum (IDLE, PACK, FLUSH, DRAIN, DONE);
  - constant CRC8_POLY = 8'h07;
  - constant PACK_ACTIVE_STATE = 4'd5.
- One sub-module, t05_byte_fifo:
  - parameterised depth, 8-bit wide, first-word fall-through;
  - push/pop/full/empty/count;
  - active-low async reset.

Test Plan:
- Stream 16 bits 1010_1100_0000_1111 with `byte_ready`=1 → `byte_out` 0xAC then 0x0F, `byte_count`=2.
- Stream 11 bits 1111_1111_101, then `flush` → bytes 0xFF, 0xA0; `done` rises after both handshakes.
- Hold `byte_ready`=0 and push 8·FIFO_DEPTH bits → `stall`=1 after the 4th byte and the next bit is dropped. Release ready → bytes 1..4 come out in order, each held stable while not accepted.
- 8th bit and `flush` in the same cycle → exactly one byte emitted, no zero pad byte.
- Assert rst low mid-byte with 2 bytes queued → `byte_valid`=0 and `byte_count`=0 immediately. A subsequent 8-bit stream yields exactly one byte.
- With T05_BIT_PACKER_CRC_EN: bytes 0x01, 0x02 then `flush` → CRC byte 0x1B follows (0x01 → 0x07, then 0x07^0x02 = 0x05 → 0x1B), `byte_count`=3.
